// File: rtl/pcs_am_pkg.sv
// Shared 40GBASE-R alignment-marker definitions used by the transmit inserter
// and the receive deskew/lock path.
package pcs_am_pkg;

    localparam int PCS_LANE_N  = 4;
    localparam int PCS_BLOCK_W = 66;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [1:0] SYNC_DATA = 2'b01;

    typedef logic [PCS_BLOCK_W-1:0] block_t;

    // Low half of the lane marker: {M2,M1,M0}.
    function automatic logic [23:0] am_lo(input int unsigned lane);
        logic [23:0] r;
        case (lane)
            0:       r = 24'h477690;
            1:       r = 24'he6c4f0;
            2:       r = 24'h9b65c5;
            default: r = 24'h3d79a2;
        endcase
        return r;
    endfunction

    // High half of the lane marker: {M6,M5,M4}.
    function automatic logic [23:0] am_hi(input int unsigned lane);
        logic [23:0] r;
        case (lane)
            0:       r = 24'hb8896f;
            1:       r = 24'h193b0f;
            2:       r = 24'h649a3a;
            default: r = 24'hc2865d;
        endcase
        return r;
    endfunction

    // Payload bit p lands in BIP3[(p+2) mod 8]: fold the eight payload bytes,
    // rotate left by two, then add the sync-header bits at positions 3 and 4.
    function automatic logic [7:0] bip3_contrib(input block_t blk);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 8; k++) begin
            x = x ^ blk[k*8 +: 8];
        end
        return {x[5:0], x[7:6]} ^ {3'b000, blk[64], blk[65], 3'b000};
    endfunction

    function automatic block_t build_marker(input int unsigned lane, input logic [7:0] bip3);
        return {SYNC_CTRL, ~bip3, am_hi(lane), bip3, am_lo(lane)};
    endfunction

endpackage

// File: rtl/am_bip_lane.sv
// Per-lane BIP3 accumulator: seed with one block's parity, fold in another
// block's parity, or hold.
module am_bip_lane
    import pcs_am_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       seed_i,
    input  logic       xor_i,
    input  block_t     blk_i,
    output logic [7:0] bip_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [7:0] contrib;

    always_comb begin
        contrib = bip3_contrib(blk_i);
        acc_d   = acc_q;
        if (seed_i) begin
            acc_d = contrib;
        end else if (xor_i) begin
            acc_d = acc_q ^ contrib;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bip_o = acc_q;

endmodule

// File: rtl/am_tx.sv
// 40GBASE-R transmit alignment-marker inserter: after every AM_PERIOD accepted
// blocks, one cycle of markers is emitted on all lanes while upstream is stalled.
module am_tx
    import pcs_am_pkg::*;
#(
    parameter int LANE_N    = PCS_LANE_N,
    parameter int BLOCK_W   = PCS_BLOCK_W,
    parameter int AM_PERIOD = 16383
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [LANE_N*BLOCK_W-1:0] data_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic                      am_v_o,
    output logic [LANE_N*BLOCK_W-1:0] data_o
);

    localparam int CNT_W = $clog2(AM_PERIOD + 1);

    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic [LANE_N*BLOCK_W-1:0] data_q,  data_d;
    logic                      valid_q, valid_d;
    logic                      am_v_q,  am_v_d;

    logic                      insert;
    logic                      accept;
    logic [LANE_N*BLOCK_W-1:0] marker_w;

    // ready_o depends only on the registered count, never on valid_i.
    assign insert  = (cnt_q == CNT_W'(AM_PERIOD));
    assign accept  = valid_i & ~insert;
    assign ready_o = ~insert;

    generate
        for (genvar gi = 0; gi < LANE_N; gi++) begin : g_lane
            logic [7:0] bip_w;
            block_t     lane_blk;

            assign marker_w[gi*BLOCK_W +: BLOCK_W] = build_marker(gi, bip_w);
            // On a marker cycle the accumulator restarts from the marker's own
            // parity, BIP bytes included.
            assign lane_blk = insert ? marker_w[gi*BLOCK_W +: BLOCK_W]
                                     : data_i[gi*BLOCK_W +: BLOCK_W];

            am_bip_lane u_bip (
                .clk    (clk),
                .nreset (nreset),
                .seed_i (insert),
                .xor_i  (accept),
                .blk_i  (lane_blk),
                .bip_o  (bip_w)
            );
        end
    endgenerate

    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        am_v_d  = 1'b0;
        if (insert) begin
            data_d  = marker_w;
            valid_d = 1'b1;
            am_v_d  = 1'b1;
            cnt_d   = '0;
        end else if (valid_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            am_v_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            am_v_q  <= am_v_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign am_v_o  = am_v_q;

endmodule
